mantis_sprite_addr_gen: RTL and testbench
=========================================

# mantis_sprite_addr_gen

Per-pixel ROM address generator for the mantis idle animation. It sits directly upstream of the sprite ROM/palette stage and consumes the VGA controller's DrawX/DrawY/blank. It places a 31x156 sprite at a runtime position, optionally mirrored, and steps through animation frames stored back-to-back in ROM. It replaces the full-screen stretch divider with an exact, divider-free address and a `sprite_on` qualifier for compositing.

## Interface
- SPR_W, 31: sprite width in pixels.
- SPR_H, 156: sprite height in pixels.
- NUM_FRAMES, 4: animation frames stored consecutively in ROM, each SPR_W*SPR_H words.
- FRAME_HOLD, 8: video frames each animation frame is displayed.
- ADDR_W, 15: ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H*NUM_FRAMES.
- vga_clk  in  1  pixel clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column, 0..639.
- DrawY  in  10  current pixel row, 0..479.
- blank  in  1  1 = active video.
- pos_x  in  10  sprite top-left column; sampled at frame start.
- pos_y  in  10  sprite top-left row; sampled at frame start.
- flip  in  1  1 = horizontal mirror; sampled at frame start.
- anim_en  in  1  1 = animation advances; sampled at frame start.
- anim_restart  in  1  single-cycle request to return to frame 0.
- rom_address  out  ADDR_W  registered ROM address.
- sprite_on  out  1  registered; 1 = the pixel lies inside the sprite during active video.
- frame_idx  out  $clog2(NUM_FRAMES)  current animation frame.
- frame_start  out  1  registered one-cycle pulse at the start of each video frame.

## Operation
**Frame start**
- Condition: (DrawX,DrawY)==(0,0) this cycle, and the previous cycle was not (0,0).
- On that edge:
  - frame_start <= 1.
  - The shadow registers sx, sy, sflip and sen load pos_x, pos_y, flip and anim_en.

**Hit test**
- All compares are 11-bit.
- in_x = DrawX >= sx && DrawX < sx+SPR_W.
- in_y = DrawY >= sy && DrawY < sy+SPR_H.
- A sprite that extends past column 639 or row 479 is clipped. It never wraps onto the next line or frame.

**Address**
- col = DrawX - sx; row = DrawY - sy.
- col' = sflip ? SPR_W-1-col : col.
- offset = row*SPR_W + col'. The multiply is implemented as (row<<5) - row for SPR_W=31; no generic multiplier or divider.
- rom_address <= frame_base + offset when in_x && in_y, otherwise frame_base.
- sprite_on <= in_x && in_y && blank.

**Animation FSM**
- State is hold_cnt (0..FRAME_HOLD-1), frame_idx, and frame_base = frame_idx*SPR_W*SPR_H.
- frame_base is kept as a register and updated by adding SPR_W*SPR_H, or resetting to 0.
- RUN (sen=1) at frame start:
  - If hold_cnt == FRAME_HOLD-1: hold_cnt <= 0 and frame_idx advances. Past NUM_FRAMES-1 it wraps to 0, and frame_base wraps to 0 with it.
  - Otherwise hold_cnt increments.
- PAUSED (sen=0): hold_cnt and frame_idx are frozen, not cleared.
- The FSM evaluates using the anim_en value being sampled on that same edge.

**Restart**
- An anim_restart pulse sets restart_pend.
- At the next frame start: frame_idx, hold_cnt and frame_base <= 0, and restart_pend clears.
- Restart has priority over advance.
- A pulse coincident with a frame start is applied at that same frame start.

## Timing
- Latency is 1 cycle: outputs at cycle t+1 correspond to DrawX/DrawY/blank at cycle t. The downstream ROM samples on negedge, so ROM data is valid for the posedge at t+2.
- The address for pixel (0,0) uses the pre-update shadow and frame values. New values take effect from pixel (1,0).
- frame_idx and frame_base change on the frame-start edge, so they are constant for the rest of the frame.
- Reset values: rom_address 0, sprite_on 0, frame_idx 0, frame_start 0. sx, sy, sflip, sen, hold_cnt, frame_base and restart_pend are all 0.
- Reset asserted mid-frame:
  - All state clears immediately and asynchronously.
  - After release, the next (0,0) produces a frame_start, because the previous-cycle tracker resets to "not (0,0)".

## Test plan
- **Basic placement:** pos (100,50), flip 0, one frame start.
  - (100,50) -> rom_address 0, sprite_on 1.
  - (130,50) -> 30.
  - (131,50) -> sprite_on 0, rom_address 0.
  - (130,205) -> 4835.
  - (130,206) -> sprite_on 0.
- **Flip:** same position, flip 1. (100,50) -> 30; (130,50) -> 0; (100,51) -> 61.
- **Animation:** anim_en 1, FRAME_HOLD 8.
  - After 8 frame starts, frame_idx 1 and (100,50) -> 4836.
  - After 32 frame starts, frame_idx wraps to 0.
  - With anim_en 0 for 5 frames, frame_idx and hold_cnt are unchanged.
- **Clipping:** pos_x 620.
  - (639,60) -> sprite_on 1, rom_address (60-pos_y)*31+19.
  - (0,61) -> sprite_on 0.
  - blank 0 inside the sprite -> sprite_on 0, with the address still computed.
- **Restart:** pulse anim_restart mid-frame at frame_idx 2 -> frame_idx stays 2 until the next frame start, then 0, with hold_cnt 0. A pulse on the frame-start cycle applies immediately.
- **Reset mid-frame:** assert reset_n low at (300,200) with frame_idx 3 -> all outputs 0 asynchronously. After release, the first (0,0) produces frame_start 1.

Source files
------------

// File: rtl/mantis_sprite_addr_gen.sv
// Mantis idle sprite: per-pixel ROM address, hit qualifier
// and frame-hold animation sequencer.
module mantis_sprite_addr_gen #(
  parameter int SPR_W      = 31,
  parameter int SPR_H      = 156,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_HOLD = 8,
  parameter int ADDR_W     = 15
) (
  input  logic                          vga_clk,
  input  logic                          reset_n,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          blank,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          flip,
  input  logic                          anim_en,
  input  logic                          anim_restart,
  output logic [ADDR_W-1:0]             rom_address,
  output logic                          sprite_on,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          frame_start
);

  localparam int FI_W   = $clog2(NUM_FRAMES);
  localparam int HOLD_W = $clog2(FRAME_HOLD);
  localparam int COL_W  = $clog2(SPR_W);
  localparam int ROW_W  = $clog2(SPR_H);
  localparam int ROW_SH = $clog2(SPR_W + 1);

  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);
  localparam logic [FI_W-1:0]   LAST_FRAME  = FI_W'(NUM_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(SPR_W - 1);
  localparam logic [10:0]       W11         = 11'(SPR_W);
  localparam logic [10:0]       H11         = 11'(SPR_H);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } mode_t;

  logic              at_origin;
  logic              prev_origin;
  logic              sof;

  logic [9:0]        sx;
  logic [9:0]        sy;
  logic              sflip;

  mode_t             sen;
  mode_t             sen_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [FI_W-1:0]   idx_q;
  logic [FI_W-1:0]   idx_nxt;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] base_nxt;
  logic              restart_pend;
  logic              pend_nxt;

  logic              do_restart;
  logic              do_step;
  logic              at_hold_last;
  logic              at_last_frame;

  logic [10:0]       x11;
  logic [10:0]       y11;
  logic [10:0]       sx11;
  logic [10:0]       sy11;
  logic              in_x;
  logic              in_y;
  logic              hit;

  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_f;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_a;
  logic [ADDR_W-1:0] offset;

  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign sof       = at_origin && !prev_origin;

  assign x11  = {1'b0, DrawX};
  assign y11  = {1'b0, DrawY};
  assign sx11 = {1'b0, sx};
  assign sy11 = {1'b0, sy};

  // 11-bit bounds so a sprite near the edge clips instead of wrapping
  assign in_x = (x11 >= sx11) && (x11 < sx11 + W11);
  assign in_y = (y11 >= sy11) && (y11 < sy11 + H11);
  assign hit  = in_x && in_y;

  assign col   = DrawX[COL_W-1:0] - sx[COL_W-1:0];
  assign row   = DrawY[ROW_W-1:0] - sy[ROW_W-1:0];
  assign col_f = sflip ? COL_LAST - col : col;
  assign row_a = ADDR_W'(row);

  // row*31 as shift-and-subtract, no multiplier
  assign offset = (row_a << ROW_SH) - row_a + ADDR_W'(col_f);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_origin <= 1'b0;
      frame_start <= 1'b0;
      sprite_on   <= 1'b0;
      rom_address <= '0;
      sx          <= '0;
      sy          <= '0;
      sflip       <= 1'b0;
    end else begin
      prev_origin <= at_origin;
      frame_start <= sof;
      sprite_on   <= hit && blank;
      rom_address <= hit ? frame_base + offset : frame_base;
      if (sof) begin
        sx    <= pos_x;
        sy    <= pos_y;
        sflip <= flip;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      sen          <= PAUSED;
      hold_cnt     <= '0;
      idx_q        <= '0;
      frame_base   <= '0;
      restart_pend <= 1'b0;
    end else begin
      sen          <= sen_nxt;
      hold_cnt     <= hold_nxt;
      idx_q        <= idx_nxt;
      frame_base   <= base_nxt;
      restart_pend <= pend_nxt;
    end
  end

  always_comb begin
    sen_nxt  = sen;
    hold_nxt = hold_cnt;
    idx_nxt  = idx_q;
    base_nxt = frame_base;
    pend_nxt = restart_pend || anim_restart;
    if (sof) begin
      sen_nxt  = anim_en ? RUN : PAUSED;
      pend_nxt = 1'b0;
    end
    unique case (1'b1)
      do_restart: begin
        hold_nxt = '0;
        idx_nxt  = '0;
        base_nxt = '0;
      end
      do_step: begin
        if (at_hold_last) begin
          hold_nxt = '0;
          if (at_last_frame) begin
            idx_nxt  = '0;
            base_nxt = '0;
          end else begin
            idx_nxt  = idx_q + FI_W'(1);
            base_nxt = frame_base + FRAME_WORDS;
          end
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: ;
    endcase
  end

  // anim_en is used live so the edge that samples it also acts on it
  always_comb begin
    do_restart    = sof && (restart_pend || anim_restart);
    do_step       = sof && !do_restart && anim_en;
    at_hold_last  = (hold_cnt == HOLD_LAST);
    at_last_frame = (idx_q == LAST_FRAME);
    frame_idx     = idx_q;
  end

endmodule

// File: tb/tb_mantis_sprite_addr_gen.sv
// Bench for mantis_sprite_addr_gen: directed plan items plus
// random pixels against a frame-count behavioural model.
module tb_mantis_sprite_addr_gen;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        flip;
  logic        anim_en;
  logic        anim_restart;
  logic [14:0] rom_address;
  logic        sprite_on;
  logic [1:0]  frame_idx;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  int m_sx, m_sy, m_flip, m_run, m_pend, m_prev;

  always #5 vga_clk = ~vga_clk;

  mantis_sprite_addr_gen dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .flip         (flip),
    .anim_en      (anim_en),
    .anim_restart (anim_restart),
    .rom_address  (rom_address),
    .sprite_on    (sprite_on),
    .frame_idx    (frame_idx),
    .frame_start  (frame_start)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sx   = 0;
    m_sy   = 0;
    m_flip = 0;
    m_run  = 0;
    m_pend = 0;
    m_prev = 0;
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // m_run counts advancing frame starts since restart, mod 32
  task automatic step(input int x, input int y, input bit b, input bit rs);
    int  e_addr, e_on, e_fs, idx, row, col;
    bit  inx, iny, o;
    DrawX        = 10'(x);
    DrawY        = 10'(y);
    blank        = b;
    anim_restart = rs;
    idx    = (m_run / 8) % 4;
    inx    = (x >= m_sx) && (x < m_sx + 31);
    iny    = (y >= m_sy) && (y < m_sy + 156);
    row    = y - m_sy;
    col    = x - m_sx;
    if (m_flip != 0) col = 30 - col;
    e_addr = idx * 4836 + ((inx && iny) ? row * 31 + col : 0);
    e_on   = (inx && iny && b) ? 1 : 0;
    o      = (x == 0) && (y == 0);
    e_fs   = (o && m_prev == 0) ? 1 : 0;
    m_prev = o ? 1 : 0;
    if (e_fs != 0) begin
      if (m_pend != 0 || rs) m_run = 0;
      else if (anim_en) m_run = (m_run + 1) % 32;
      m_pend = 0;
      m_sx   = int'(pos_x);
      m_sy   = int'(pos_y);
      m_flip = int'(flip);
    end else if (rs) begin
      m_pend = 1;
    end
    @(posedge vga_clk);
    #1;
    check("rom_address", int'(rom_address), e_addr);
    check("sprite_on", int'(sprite_on), e_on);
    check("frame_start", int'(frame_start), e_fs);
    check("frame_idx", int'(frame_idx), (m_run / 8) % 4);
    anim_restart = 1'b0;
  endtask

  task automatic frame(input bit rs);
    step(7, 3, 1'b1, 1'b0);
    step(0, 0, 1'b1, rs);
  endtask

  initial begin
    int x, y, r;
    reset_n      = 1'b0;
    DrawX        = '0;
    DrawY        = '0;
    blank        = 1'b0;
    pos_x        = '0;
    pos_y        = '0;
    flip         = 1'b0;
    anim_en      = 1'b0;
    anim_restart = 1'b0;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_addr", int'(rom_address), 0);
    check("rst_on", int'(sprite_on), 0);
    check("rst_idx", int'(frame_idx), 0);
    check("rst_fs", int'(frame_start), 0);
    reset_n = 1'b1;

    pos_x = 10'd100;
    pos_y = 10'd50;
    step(5, 5, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0);
    check("lit_fs_first", int'(frame_start), 1);
    step(100, 50, 1'b1, 1'b0);
    check("lit_basic_org", int'(rom_address), 0);
    check("lit_basic_on", int'(sprite_on), 1);
    step(130, 50, 1'b1, 1'b0);
    check("lit_basic_130", int'(rom_address), 30);
    step(131, 50, 1'b1, 1'b0);
    check("lit_basic_131_on", int'(sprite_on), 0);
    check("lit_basic_131_a", int'(rom_address), 0);
    step(130, 205, 1'b1, 1'b0);
    check("lit_basic_last", int'(rom_address), 4835);
    step(130, 206, 1'b1, 1'b0);
    check("lit_basic_206", int'(sprite_on), 0);

    flip = 1'b1;
    frame(1'b0);
    step(100, 50, 1'b1, 1'b0);
    check("lit_flip_100", int'(rom_address), 30);
    step(130, 50, 1'b1, 1'b0);
    check("lit_flip_130", int'(rom_address), 0);
    step(100, 51, 1'b1, 1'b0);
    check("lit_flip_r1", int'(rom_address), 61);

    flip  = 1'b0;
    pos_x = 10'd620;
    frame(1'b0);
    step(639, 60, 1'b1, 1'b0);
    check("lit_clip_on", int'(sprite_on), 1);
    check("lit_clip_addr", int'(rom_address), 329);
    step(0, 61, 1'b1, 1'b0);
    check("lit_clip_nowrap", int'(sprite_on), 0);
    step(630, 60, 1'b0, 1'b0);
    check("lit_blank_on", int'(sprite_on), 0);
    check("lit_blank_addr", int'(rom_address), 320);

    pos_x   = 10'd100;
    anim_en = 1'b1;
    repeat (8) frame(1'b0);
    check("lit_anim_8", int'(frame_idx), 1);
    step(100, 50, 1'b1, 1'b0);
    check("lit_anim_base", int'(rom_address), 4836);
    repeat (24) frame(1'b0);
    check("lit_anim_wrap", int'(frame_idx), 0);
    repeat (3) frame(1'b0);
    anim_en = 1'b0;
    repeat (5) frame(1'b0);
    check("lit_pause_idx", int'(frame_idx), 0);
    anim_en = 1'b1;
    repeat (5) frame(1'b0);
    check("lit_pause_hold", int'(frame_idx), 1);

    repeat (8) frame(1'b0);
    check("lit_rs_pre", int'(frame_idx), 2);
    step(200, 100, 1'b1, 1'b1);
    step(201, 100, 1'b1, 1'b0);
    check("lit_rs_wait", int'(frame_idx), 2);
    frame(1'b0);
    check("lit_rs_apply", int'(frame_idx), 0);
    repeat (7) frame(1'b0);
    check("lit_rs_hold7", int'(frame_idx), 0);
    frame(1'b0);
    check("lit_rs_hold8", int'(frame_idx), 1);
    frame(1'b1);
    check("lit_rs_coinc", int'(frame_idx), 0);

    repeat (24) frame(1'b0);
    check("lit_rst_pre", int'(frame_idx), 3);
    step(300, 200, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("lit_arst_addr", int'(rom_address), 0);
    check("lit_arst_on", int'(sprite_on), 0);
    check("lit_arst_idx", int'(frame_idx), 0);
    check("lit_arst_fs", int'(frame_start), 0);
    #2;
    reset_n = 1'b1;
    model_reset();
    step(0, 0, 1'b1, 1'b0);
    check("lit_arst_fs1", int'(frame_start), 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pos_x   = 10'($urandom_range(0, 1) != 0 ? $urandom_range(600, 639)
                                               : $urandom_range(0, 639));
        pos_y   = 10'($urandom_range(0, 1) != 0 ? $urandom_range(400, 479)
                                               : $urandom_range(0, 479));
        flip    = 1'($urandom_range(0, 1));
        anim_en = ($urandom_range(0, 3) != 0);
      end
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        x = 0;
        y = 0;
      end else if (r < 12) begin
        x = clampi(m_sx + int'($urandom_range(0, 40)) - 5, 0, 639);
        y = clampi(m_sy + int'($urandom_range(0, 165)) - 5, 0, 479);
      end else begin
        x = int'($urandom_range(0, 639));
        y = int'($urandom_range(0, 479));
      end
      step(x, y, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
